// File: rtl/ahb3lite_rr_master_arb_pkg.sv
// rtl/ahb3lite_rr_master_arb_pkg.sv - AHB-Lite constants, arbiter state type and alignment helper
package ahb3lite_rr_master_arb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ADDR,
        ARB_DATA
    } arb_state_e;

    // Sizes wider than a word are never legal on this 32-bit bus.
    function automatic logic hsize_aligned(input logic [1:0] addr_lsbs, input logic [2:0] size);
        case (size)
            HSIZE_BYTE:  return 1'b1;
            HSIZE_HWORD: return !addr_lsbs[0];
            HSIZE_WORD:  return addr_lsbs == 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb3lite_rr_master_arb_if.sv
// rtl/ahb3lite_rr_master_arb_if.sv - AHB-Lite master bus interface (HMASTLOCK with ARB_LOCK_EN)
interface ahb3lite_rr_master_arb_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [DATA_W-1:0] HWDATA;
    logic              HREADY;
    logic [DATA_W-1:0] HRDATA;
    logic              HRESP;
`ifdef ARB_LOCK_EN
    logic              HMASTLOCK;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HMASTLOCK,
        input  HREADY, HRDATA, HRESP
    );
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HMASTLOCK,
        output HREADY, HRDATA, HRESP
    );
`else
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HREADY, HRDATA, HRESP
    );
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HREADY, HRDATA, HRESP
    );
`endif
endinterface

// File: rtl/ahb3lite_rr_master_arb_rr_arbiter_core.sv
// rtl/ahb3lite_rr_master_arb_rr_arbiter_core.sv - round-robin pick: first request above ptr, wrapping
module rr_arbiter_core #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 1; i <= N; i++) begin
            int j;
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IW'(j);
            end
        end
    end

endmodule

// File: rtl/ahb3lite_rr_master_arb.sv
// rtl/ahb3lite_rr_master_arb.sv - round-robin requester-to-AHB-Lite master sequencer
// Optional macro ARB_LOCK_EN: req_lock inputs, HMASTLOCK, sticky re-grant of locked sequences.
module ahb3lite_rr_master_arb
    import ahb3lite_rr_master_arb_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter int         ADDR_W    = 16,
    parameter int         DATA_W    = 32,
    parameter logic [3:0] HPROT_VAL = 4'b0011
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*3-1:0]      req_size,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
`ifdef ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        done,
    output logic                      err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    ahb3lite_rr_master_arb_if.master  bus
);

    localparam int IW = $clog2(NUM_REQ);

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     ptr_q, g_q, core_idx, gsel;
    logic [NUM_REQ-1:0] req_eff, core_grant, gvec;
    logic              core_any, gany;
    logic [ADDR_W-1:0] addr_q, sel_addr;
    logic [2:0]        size_q, sel_size;
    logic              write_q, sel_ok;
    logic [DATA_W-1:0] wdata_q;

    // A requester still sees its done pulse this cycle, so it must not be re-granted yet.
    assign req_eff = req & ~done;

    rr_arbiter_core #(.N(NUM_REQ)) u_core (
        .req   (req_eff),
        .ptr   (ptr_q),
        .grant (core_grant),
        .idx   (core_idx),
        .any   (core_any)
    );

`ifdef ARB_LOCK_EN
    logic lock_q, lock_seq_q, lock_hit;
    assign lock_hit = lock_q && req[g_q];
    assign gsel     = lock_hit ? g_q : core_idx;
    assign gany     = lock_hit || core_any;
    assign gvec     = lock_hit ? (NUM_REQ'(1) << g_q) : core_grant;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            lock_q     <= 1'b0;
            lock_seq_q <= 1'b0;
        end else if (state_q == ARB_IDLE && gany) begin
            lock_q     <= 1'b0;
            lock_seq_q <= req_lock[gsel];
        end else if (state_q == ARB_DATA && bus.HREADY) begin
            lock_q     <= !bus.HRESP && req_lock[g_q] && req[g_q];
        end
    end

    assign bus.HMASTLOCK = (state_q == ARB_ADDR) && lock_seq_q;
`else
    assign gsel = core_idx;
    assign gany = core_any;
    assign gvec = core_grant;
`endif

    assign sel_addr = req_addr[int'(gsel)*ADDR_W +: ADDR_W];
    assign sel_size = req_size[int'(gsel)*3 +: 3];
    assign sel_ok   = hsize_aligned(sel_addr[1:0], sel_size);

    always_ff @(posedge HCLK) begin
        if (HRESET) state_q <= ARB_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: if (gany && sel_ok) state_d = ARB_ADDR;
            ARB_ADDR: if (bus.HREADY)     state_d = ARB_DATA;
            ARB_DATA: if (bus.HREADY)     state_d = ARB_IDLE;
            default:                      state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        bus.HSEL   = (state_q == ARB_ADDR);
        bus.HTRANS = (state_q == ARB_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
        bus.HADDR  = addr_q;
        bus.HSIZE  = size_q;
        bus.HWRITE = write_q;
        bus.HWDATA = wdata_q;
        bus.HBURST = HBURST_SINGLE;
        bus.HPROT  = HPROT_VAL;
        busy       = (state_q != ARB_IDLE);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ptr_q   <= IW'(NUM_REQ - 1);
            g_q     <= '0;
            addr_q  <= '0;
            size_q  <= HSIZE_BYTE;
            write_q <= 1'b0;
            wdata_q <= '0;
            done    <= '0;
            err     <= 1'b0;
            rdata   <= '0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            if (state_q == ARB_IDLE && gany) begin
                g_q     <= gsel;
                ptr_q   <= gsel;
                addr_q  <= sel_addr;
                size_q  <= sel_size;
                write_q <= req_write[gsel];
                wdata_q <= req_wdata[int'(gsel)*DATA_W +: DATA_W];
                if (!sel_ok) begin
                    done  <= gvec;
                    err   <= 1'b1;
                    rdata <= '0;
                end
            end else if (state_q == ARB_DATA && bus.HREADY) begin
                done  <= NUM_REQ'(1) << g_q;
                err   <= bus.HRESP;
                rdata <= (!write_q && !bus.HRESP) ? bus.HRDATA : '0;
            end
        end
    end

    a_htrans_legal: assert property (@(posedge HCLK) disable iff (HRESET)
        bus.HTRANS == HTRANS_IDLE || bus.HTRANS == HTRANS_NONSEQ);
    a_addr_stable: assert property (@(posedge HCLK) disable iff (HRESET)
        (state_q == ARB_ADDR && !bus.HREADY) |=>
        ($stable(bus.HADDR) && $stable(bus.HSIZE) && $stable(bus.HWRITE) && bus.HTRANS == HTRANS_NONSEQ));
    a_wdata_stable: assert property (@(posedge HCLK) disable iff (HRESET)
        (state_q == ARB_DATA && !bus.HREADY) |=> $stable(bus.HWDATA));
    a_done_onehot: assert property (@(posedge HCLK) $onehot0(done));

endmodule
